// File: rtl/speed_timer_pkg.sv
// Shared speed codes and widths for the speed timer and its shift logic.
package speed_timer_pkg;

  localparam int unsigned SPEED_W = 4;
  localparam int unsigned CNT_W   = 8;

  localparam logic [SPEED_W-1:0] SPEED1 = 4'b0001;
  localparam logic [SPEED_W-1:0] SPEED2 = 4'b0010;
  localparam logic [SPEED_W-1:0] SPEED3 = 4'b0100;
  localparam logic [SPEED_W-1:0] SPEED4 = 4'b1000;

  // True only for one of the four legal speed codes.
  function automatic logic is_onehot(input logic [SPEED_W-1:0] v);
    return (v == SPEED1) || (v == SPEED2) || (v == SPEED3) || (v == SPEED4);
  endfunction

endpackage

// File: rtl/speed_shift.sv
// Next-speed computation from single-cycle shift pulses, saturating at both ends.
module speed_shift
  import speed_timer_pkg::*;
(
  input  logic [SPEED_W-1:0] cur,
  input  logic               shl,
  input  logic               shr,
  output logic [SPEED_W-1:0] nxt_c
);

  // shr steps toward SPEED1, shl toward SPEED4; both or neither hold.
  always_comb begin
    nxt_c = cur;
    if (shr && !shl) begin
      case (cur)
        SPEED2:  nxt_c = SPEED1;
        SPEED3:  nxt_c = SPEED2;
        SPEED4:  nxt_c = SPEED3;
        default: nxt_c = cur;
      endcase
    end else if (shl && !shr) begin
      case (cur)
        SPEED1:  nxt_c = SPEED2;
        SPEED2:  nxt_c = SPEED3;
        SPEED3:  nxt_c = SPEED4;
        default: nxt_c = cur;
      endcase
    end
  end

endmodule

// File: rtl/speed_timer.sv
// Four-speed tick generator: button edge detect, speed selection with one-hot
// recovery, and a run-gated prescaler that emits ticks and counts them.
module speed_timer
  import speed_timer_pkg::*;
#(
  parameter int unsigned DIV1 = 4,
  parameter int unsigned DIV2 = 8,
  parameter int unsigned DIV3 = 16,
  parameter int unsigned DIV4 = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               shl_btn,
  input  logic               shr_btn,
  output logic [SPEED_W-1:0] speed,
  output logic               tick,
  output logic [CNT_W-1:0]   tick_count
);

  localparam logic [CNT_W-1:0] LAST1 = CNT_W'(DIV1 - 1);
  localparam logic [CNT_W-1:0] LAST2 = CNT_W'(DIV2 - 1);
  localparam logic [CNT_W-1:0] LAST3 = CNT_W'(DIV3 - 1);
  localparam logic [CNT_W-1:0] LAST4 = CNT_W'(DIV4 - 1);

  logic               shl_q;
  logic               shr_q;
  logic               shl_pulse_c;
  logic               shr_pulse_c;
  logic [SPEED_W-1:0] speed_q;
  logic [SPEED_W-1:0] shift_c;
  logic [SPEED_W-1:0] speed_nxt_c;
  logic               chg_c;
  logic [CNT_W-1:0]   last_c;
  logic [CNT_W-1:0]   cnt_q;
  logic               tick_q;
  logic [CNT_W-1:0]   tick_count_q;

  assign shl_pulse_c = shl_btn & ~shl_q;
  assign shr_pulse_c = shr_btn & ~shr_q;

  speed_shift u_shift (
    .cur   (speed_q),
    .shl   (shl_pulse_c),
    .shr   (shr_pulse_c),
    .nxt_c (shift_c)
  );

  // An illegal speed code snaps back to the fastest speed.
  always_comb begin
    speed_nxt_c = SPEED1;
    if (is_onehot(speed_q)) begin
      speed_nxt_c = shift_c;
    end
    chg_c = (speed_nxt_c != speed_q);
  end

  // Terminal prescaler value for the current speed.
  always_comb begin
    last_c = LAST1;
    case (speed_q)
      SPEED2:  last_c = LAST2;
      SPEED3:  last_c = LAST3;
      SPEED4:  last_c = LAST4;
      default: last_c = LAST1;
    endcase
  end

  // A real speed change restarts the period and wins over a terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shl_q        <= 1'b0;
      shr_q        <= 1'b0;
      speed_q      <= SPEED1;
      cnt_q        <= '0;
      tick_q       <= 1'b0;
      tick_count_q <= '0;
    end else begin
      shl_q   <= shl_btn;
      shr_q   <= shr_btn;
      speed_q <= speed_nxt_c;
      tick_q  <= 1'b0;
      if (chg_c) begin
        cnt_q <= '0;
      end else if (run) begin
        if (cnt_q == last_c) begin
          cnt_q        <= '0;
          tick_q       <= 1'b1;
          tick_count_q <= tick_count_q + CNT_W'(1);
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign speed      = speed_q;
  assign tick       = tick_q;
  assign tick_count = tick_count_q;

endmodule

// File: doc/speed_timer.md
SPEED_TIMER -- requirements
Module: speed_timer

Interface
REQ-001 SHALL have parameter DIV1, default 4, meaning tick period in clk cycles at SPEED1 (fastest).
REQ-002 SHALL have parameter DIV2, default 8, meaning tick period at SPEED2.
REQ-003 SHALL have parameter DIV3, default 16, meaning tick period at SPEED3.
REQ-004 SHALL have parameter DIV4, default 32, meaning tick period at SPEED4 (slowest); all DIVn in 2..256.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-007 SHALL have port run  input  1  level; 1 lets the tick prescaler advance, 0 freezes it.
REQ-008 SHALL have port shl_btn  input  1  level request to slow down (left shift).
REQ-009 SHALL have port shr_btn  input  1  level request to speed up (right shift).
REQ-010 SHALL have port speed  output  4  registered one-hot current speed: 0001, 0010, 0100 or 1000.
REQ-011 SHALL have port tick  output  1  registered one-cycle pulse once per tick period.
REQ-012 SHALL have port tick_count  output  8  registered count of ticks issued, wrapping 255->0.

Function
REQ-013 SHALL register shl_btn and shr_btn every cycle; a shift pulse is btn high while its registered copy is low, i.e. one pulse per rising edge, never repeated while held.
REQ-014 SHALL compute next speed from the shift pulses and the current speed: shr only -> one step faster, saturating at 0001; shl only -> one step slower, saturating at 1000; both or neither -> unchanged.
REQ-015 SHALL load next speed into speed on the same clock edge that registers the button, so speed changes one edge after the button is first sampled high.
REQ-016 SHALL load 0001 into speed if the current speed is not one-hot, regardless of the pulses.
REQ-017 SHALL select the active divisor DIVn from the current speed: 0001->DIV1, 0010->DIV2, 0100->DIV3, 1000->DIV4.
REQ-018 SHALL keep an internal prescaler count; with run=1 and no speed change it increments each cycle, and at count=DIVn-1 it returns to 0 and tick is 1 on the next cycle.
REQ-019 SHALL therefore produce, with run held at 1, tick pulses exactly DIVn cycles apart, tick high for exactly one cycle.
REQ-020 SHALL, when run=0, hold count and tick_count and drive tick 0.
REQ-021 SHALL, on any cycle where speed actually changes value, clear the count to 0 and drive tick 0 on the next cycle; the speed change takes priority over a coinciding terminal count.
REQ-022 SHALL treat a saturated shift (no speed change) as no event: the count is not cleared.
REQ-023 SHALL increment tick_count by 1 on each cycle tick is asserted, modulo 256.

Reset
REQ-024 SHALL, while rst=1, force speed=0001, tick=0, tick_count=0, prescaler count=0 and both registered button copies=0, independent of clk.
REQ-025 SHALL, when rst asserts mid-period, discard the partial period; after release the first tick comes DIV1 cycles after the first run=1 edge.
REQ-026 SHALL treat a button already held high at reset release as one rising edge.

Structure
REQ-027 SHALL take the speed codes SPEED1..SPEED4 (0001, 0010, 0100, 1000) from the shared speed package, not local literals.
REQ-028 SHALL instantiate the existing speed_shift block for the next-speed computation; one-hot recovery and the prescaler live in speed_timer.
REQ-029 SHALL be a single module with one sub-module instance.

Verification
REQ-030 SHALL check reset then run=1 at defaults: ticks 4 cycles apart, tick_count reaches 3 after 12 cycles.
REQ-031 SHALL check shl_btn held 20 cycles from speed 0001: speed=0010 after one edge, then constant; tick period 8; count restarted at the change.
REQ-032 SHALL check four shl pulses then one extra: speed 0010, 0100, 1000, 1000 (saturated, count not cleared); then shr pulse -> 0100, period 16.
REQ-033 SHALL check shl_btn and shr_btn rising on the same cycle at speed 0100: speed stays 0100 and the prescaler is not cleared.
REQ-034 SHALL check run=0 for 10 cycles mid-period at speed 0001 (count=2): no tick, tick_count held; the next tick comes 2 cycles after run returns to 1.
REQ-035 SHALL check a forced speed of 0110 and rst pulsed mid-period: both return speed to 0001, and after reset tick_count=0 and the first tick comes at cycle 4.
